// File: rtl/sin_cos_pkg.sv
// Shared constants and tag type for the sin_cos CORDIC pipeline and its arbiter.
package sin_cos_pkg;

    localparam int ASIZE_DEF = 16;
    localparam int DSIZE_DEF = 16;
    localparam int RNUM_DEF  = 8;
    localparam int TAG_IDW   = 4;

    // Cycles from a cs_angle change to the matching cs_sin/cs_cos change.
    function automatic int LAT_OF(input int rnum);
        return rnum + 4;
    endfunction

    typedef struct packed {
        logic               vld;
        logic [TAG_IDW-1:0] id;
    } sc_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: circular first-hit search from a pointer that advances
// past the winner whenever the grant is taken.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_id,
    input  logic          accept
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_idx;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_onehot = '0;
        gnt_id     = '0;
        w_idx      = '0;
        // Walk from farthest to nearest so the nearest requester overwrites the rest.
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % N);
            if (req[w_idx]) begin
                gnt_onehot        = '0;
                gnt_onehot[w_idx] = 1'b1;
                gnt_id            = w_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (accept) begin
            r_ptr <= (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
        end
    end

endmodule

// File: rtl/sin_cos_arbiter.sv
// Shares one fixed-latency sin_cos pipeline among NREQ requesters and routes
// each result back to its originator with a tag pipeline of matching depth.
module sin_cos_arbiter
    import sin_cos_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int ASIZE = ASIZE_DEF,
    parameter  int DSIZE = DSIZE_DEF,
    parameter  int RNUM  = RNUM_DEF,
    localparam int LAT   = LAT_OF(RNUM),
    localparam int IDW   = $clog2(NREQ),
    localparam int CW    = $clog2(LAT + 2)
) (
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0][ASIZE-1:0]  req_angle,
    output logic [NREQ-1:0]             req_ready,
    output logic [ASIZE-1:0]            cs_angle,
    input  logic [DSIZE-1:0]            cs_sin,
    input  logic [DSIZE-1:0]            cs_cos,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [DSIZE-1:0]            rsp_sin,
    output logic [DSIZE-1:0]            rsp_cos,
    output logic [IDW-1:0]              rsp_id,
    output logic [CW-1:0]               inflight,
    output logic                        idle
);

    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_accept;
    sc_tag_t          w_tag_in;
    sc_tag_t          w_tag_out;

    logic [ASIZE-1:0] r_cs_angle;
    sc_tag_t [LAT:0]  r_tag;
    logic [NREQ-1:0]  r_rsp_valid;
    logic [DSIZE-1:0] r_rsp_sin;
    logic [DSIZE-1:0] r_rsp_cos;
    logic [IDW-1:0]   r_rsp_id;
    logic [CW-1:0]    r_inflight;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clock      (clock),
        .rst_n      (rst_n),
        .req        (req_valid),
        .gnt_onehot (w_gnt),
        .gnt_id     (w_gnt_id),
        .accept     (w_accept)
    );

    assign w_accept = |w_gnt;

    always_comb begin
        w_tag_in.vld = w_accept;
        w_tag_in.id  = w_accept ? TAG_IDW'(w_gnt_id) : '0;
    end

    // The tag is captured on the same edge as cs_angle and must reach the output
    // stage one edge after the CORDIC result changes, hence LAT+1 stages.
    assign w_tag_out = r_tag[LAT];

    always_ff @(posedge clock or negedge rst_n) begin
        // NOTE: the tag array is reset because its valid bits gate responses; stale data inside sin_cos is then harmless.
        if (!rst_n) begin
            r_cs_angle <= '0;
            r_tag      <= '0;
        end else begin
            if (w_accept) begin
                r_cs_angle <= req_angle[w_gnt_id];
            end
            r_tag[0] <= w_tag_in;
            for (int s = 1; s <= LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_sin   <= '0;
            r_rsp_cos   <= '0;
            r_rsp_id    <= '0;
        end else if (w_tag_out.vld) begin
            r_rsp_valid <= NREQ'(1) << w_tag_out.id;
            r_rsp_sin   <= cs_sin;
            r_rsp_cos   <= cs_cos;
            r_rsp_id    <= w_tag_out.id[IDW-1:0];
        end else begin
            r_rsp_valid <= '0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_tag_out.vld})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign req_ready = w_gnt;
    assign cs_angle  = r_cs_angle;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sin   = r_rsp_sin;
    assign rsp_cos   = r_rsp_cos;
    assign rsp_id    = r_rsp_id;
    assign inflight  = r_inflight;
    assign idle      = (r_inflight == '0) && (req_valid == '0);

endmodule

// File: tb/tb_sin_cos_arbiter.sv
// Directed and random checks of sin_cos_arbiter against a behavioural sin_cos
// with exact LAT delay and a small round-robin/response model.
module tb_sin_cos_arbiter;
    import sin_cos_pkg::*;

    localparam int NREQ  = 4;
    localparam int ASIZE = 16;
    localparam int DSIZE = 16;
    localparam int RNUM  = 8;
    localparam int LAT   = LAT_OF(RNUM);
    localparam int IDW   = 2;
    localparam int CW    = $clog2(LAT + 2);
    localparam int SLOTS = 64;

    logic                       clock = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NREQ-1:0]            req_valid = '0;
    logic [NREQ-1:0][ASIZE-1:0] req_angle = '0;
    logic [NREQ-1:0]            req_ready;
    logic [ASIZE-1:0]           cs_angle;
    logic [DSIZE-1:0]           cs_sin;
    logic [DSIZE-1:0]           cs_cos;
    logic [NREQ-1:0]            rsp_valid;
    logic [DSIZE-1:0]           rsp_sin;
    logic [DSIZE-1:0]           rsp_cos;
    logic [IDW-1:0]             rsp_id;
    logic [CW-1:0]              inflight;
    logic                       idle;

    always #5 clock = ~clock;

    sin_cos_arbiter #(.NREQ(NREQ), .ASIZE(ASIZE), .DSIZE(DSIZE), .RNUM(RNUM)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_angle (req_angle),
        .req_ready (req_ready),
        .cs_angle  (cs_angle),
        .cs_sin    (cs_sin),
        .cs_cos    (cs_cos),
        .rsp_valid (rsp_valid),
        .rsp_sin   (rsp_sin),
        .rsp_cos   (rsp_cos),
        .rsp_id    (rsp_id),
        .inflight  (inflight),
        .idle      (idle)
    );

    // Behavioural sin_cos: distinct, easily hand-computed functions of the angle.
    function automatic logic [DSIZE-1:0] f_sin(input logic [ASIZE-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h1234;
    endfunction

    function automatic logic [DSIZE-1:0] f_cos(input logic [ASIZE-1:0] a);
        return a + 16'h0F0F;
    endfunction

    function automatic logic [ASIZE-1:0] angle_of(input int n);
        return ASIZE'((n * 65536) / 90);
    endfunction

    logic [ASIZE-1:0] sc_pipe [LAT-1];

    always @(posedge clock) begin
        sc_pipe[0] <= cs_angle;
        for (int i = 1; i < LAT - 1; i++) sc_pipe[i] <= sc_pipe[i-1];
        cs_sin <= f_sin(sc_pipe[LAT-2]);
        cs_cos <= f_cos(sc_pipe[LAT-2]);
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int               cyc = 0;
    int               m_ptr;
    int               m_inflight;
    int               m_acc_total;
    logic [ASIZE-1:0] m_cs_angle;
    logic [DSIZE-1:0] m_rsp_sin;
    logic [DSIZE-1:0] m_rsp_cos;
    logic [IDW-1:0]   m_rsp_id;
    logic [NREQ-1:0]  e_rsp_valid;
    bit               slot_vld [SLOTS];
    int               slot_id  [SLOTS];
    logic [ASIZE-1:0] slot_ang [SLOTS];

    task automatic model_reset();
        m_ptr       = 0;
        m_inflight  = 0;
        m_cs_angle  = '0;
        m_rsp_sin   = '0;
        m_rsp_cos   = '0;
        m_rsp_id    = '0;
        e_rsp_valid = '0;
        for (int s = 0; s < SLOTS; s++) slot_vld[s] = 1'b0;
    endtask

    task automatic model_grant(output logic [NREQ-1:0] g, output int gid);
        g   = '0;
        gid = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (gid < 0 && req_valid[idx]) begin
                g[idx] = 1'b1;
                gid    = idx;
            end
        end
    endtask

    // One clock: commit the model's accept, pop any due response, land on the negedge.
    task automatic advance(input int gid);
        int s;
        int rsp;
        @(posedge clock);
        cyc++;
        rsp = 0;
        if (gid >= 0) begin
            s           = (cyc + LAT + 1) % SLOTS;
            slot_vld[s] = 1'b1;
            slot_id[s]  = gid;
            slot_ang[s] = req_angle[IDW'(gid)];
            m_cs_angle  = req_angle[IDW'(gid)];
            m_ptr       = (gid + 1) % NREQ;
            m_acc_total++;
        end
        e_rsp_valid = '0;
        s = cyc % SLOTS;
        if (slot_vld[s]) begin
            e_rsp_valid = NREQ'(1) << slot_id[s];
            m_rsp_id    = IDW'(slot_id[s]);
            m_rsp_sin   = f_sin(slot_ang[s]);
            m_rsp_cos   = f_cos(slot_ang[s]);
            slot_vld[s] = 1'b0;
            rsp = 1;
        end
        m_inflight = m_inflight + ((gid >= 0) ? 1 : 0) - rsp;
        @(negedge clock);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({cs_angle, rsp_valid, rsp_sin, rsp_cos, rsp_id, inflight} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: cs_angle=%h rsp_valid=%b rsp_sin=%h rsp_cos=%h rsp_id=%0d inflight=%0d, all must be 0",
                     cs_angle, rsp_valid, rsp_sin, rsp_cos, rsp_id, inflight);
        end
        n_checks++;
        if (idle !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_idle: got %b expected 1", idle);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_full_contention();
        logic [NREQ-1:0] g;
        int              gid;
        int              cnt [NREQ];
        for (int i = 0; i < NREQ; i++) begin
            cnt[i]       = 0;
            req_angle[i] = angle_of(10 + 20 * i);
        end
        req_valid = '1;
        for (int c = 0; c < 40; c++) begin
            #1;
            model_grant(g, gid);
            n_checks++;
            if (req_ready !== (NREQ'(1) << (c % NREQ))) begin
                n_errors++;
                $display("FAIL full_grant[%0d]: got %b expected %b", c, req_ready, NREQ'(1) << (c % NREQ));
            end
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) cnt[i]++;
            advance(gid);
            n_checks++;
            if (rsp_valid !== e_rsp_valid) begin
                n_errors++;
                $display("FAIL full_rsp_valid[%0d]: got %b expected %b", c, rsp_valid, e_rsp_valid);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            n_checks++;
            if (cnt[i] != 10) begin
                n_errors++;
                $display("FAIL full_grant_count[%0d]: got %0d expected 10", i, cnt[i]);
            end
        end
        req_valid = '0;
        for (int c = 0; c < LAT + 2; c++) begin
            #1;
            advance(-1);
            n_checks++;
            if (rsp_valid !== e_rsp_valid || (e_rsp_valid != '0 && (rsp_id !== m_rsp_id || rsp_sin !== m_rsp_sin))) begin
                n_errors++;
                $display("FAIL full_drain[%0d]: got valid=%b id=%0d sin=%h expected valid=%b id=%0d sin=%h",
                         c, rsp_valid, rsp_id, rsp_sin, e_rsp_valid, m_rsp_id, m_rsp_sin);
            end
        end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g;
        int              gid;
        int              hit_at;
        req_angle[2] = 16'h4000;
        req_valid    = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_errors++;
            $display("FAIL single_grant: got %b expected 0100", req_ready);
        end
        model_grant(g, gid);
        advance(gid);
        req_valid = '0;
        n_checks++;
        if (cs_angle !== 16'h4000) begin
            n_errors++;
            $display("FAIL single_cs_angle: got %h expected 4000", cs_angle);
        end
        n_checks++;
        if (inflight !== CW'(1)) begin
            n_errors++;
            $display("FAIL single_inflight_up: got %0d expected 1", inflight);
        end
        hit_at = 0;
        for (int k = 1; k <= LAT + 2; k++) begin
            advance(-1);
            if (rsp_valid != '0) hit_at = k;
            if (k == 13) begin
                n_checks++;
                if (rsp_valid !== 4'b0100 || rsp_id !== 2'd2 || rsp_sin !== 16'h1274 || rsp_cos !== 16'h4F0F) begin
                    n_errors++;
                    $display("FAIL single_response: got valid=%b id=%0d sin=%h cos=%h expected 0100/2/1274/4f0f",
                             rsp_valid, rsp_id, rsp_sin, rsp_cos);
                end
            end
        end
        n_checks++;
        if (hit_at != 13) begin
            n_errors++;
            $display("FAIL single_latency: last pulse at cycle %0d expected 13", hit_at);
        end
        n_checks++;
        if (inflight !== '0 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL single_inflight_down: got inflight=%0d idle=%b expected 0/1", inflight, idle);
        end
    endtask

    task automatic test_sparse();
        logic [NREQ-1:0] g;
        int              gid;
        logic [NREQ-1:0] exp_g;
        req_valid = 4'b0010;
        #1;
        model_grant(g, gid);
        advance(gid);
        req_angle[1] = angle_of(45);
        req_angle[3] = angle_of(89);
        req_valid    = 4'b1010;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_g = (c % 2 == 0) ? 4'b1000 : 4'b0010;
            n_checks++;
            if (req_ready !== exp_g) begin
                n_errors++;
                $display("FAIL sparse_grant[%0d]: got %b expected %b", c, req_ready, exp_g);
            end
            model_grant(g, gid);
            advance(gid);
        end
        req_valid = '0;
        for (int c = 0; c < LAT + 2; c++) begin
            advance(-1);
            n_checks++;
            if (rsp_valid !== e_rsp_valid || rsp_id !== m_rsp_id || rsp_cos !== m_rsp_cos) begin
                n_errors++;
                $display("FAIL sparse_rsp[%0d]: got valid=%b id=%0d cos=%h expected valid=%b id=%0d cos=%h",
                         c, rsp_valid, rsp_id, rsp_cos, e_rsp_valid, m_rsp_id, m_rsp_cos);
            end
        end
    endtask

    task automatic test_midflight_reset();
        logic [NREQ-1:0] g;
        int              gid;
        int              seen;
        for (int i = 0; i < 3; i++) begin
            req_angle[i] = angle_of(30 * i + 7);
            req_valid    = NREQ'(1) << i;
            #1;
            model_grant(g, gid);
            advance(gid);
        end
        req_valid = '0;
        repeat (5) advance(-1);
        n_checks++;
        if (inflight !== CW'(3)) begin
            n_errors++;
            $display("FAIL midreset_inflight_before: got %0d expected 3", inflight);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cs_angle, rsp_valid, rsp_sin, rsp_cos, rsp_id, inflight} !== '0 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_async_clear: cs_angle=%h rsp_valid=%b rsp_sin=%h rsp_cos=%h rsp_id=%0d inflight=%0d idle=%b",
                     cs_angle, rsp_valid, rsp_sin, rsp_cos, rsp_id, inflight, idle);
        end
        model_reset();
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        seen  = 0;
        for (int c = 0; c < 20; c++) begin
            advance(-1);
            if (rsp_valid != '0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL midreset_stale_rsp: got %0d pulses expected 0", seen);
        end
        n_checks++;
        if (idle !== 1'b1 || inflight !== '0) begin
            n_errors++;
            $display("FAIL midreset_idle: got idle=%b inflight=%0d expected 1/0", idle, inflight);
        end
        req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_errors++;
            $display("FAIL midreset_priority: got %b expected 0001", req_ready);
        end
        model_grant(g, gid);
        advance(gid);
        req_valid = '0;
    endtask

    task automatic test_soak();
        logic [NREQ-1:0] g;
        int              gid;
        logic [NREQ-1:0] pend;
        int              base_acc;
        int              expected_rsp;
        int              seen;
        pend         = '0;
        seen         = 0;
        expected_rsp = m_inflight;
        base_acc     = m_acc_total;
        for (int c = 0; c < 10000 + LAT + 3; c++) begin
            if (c < 10000) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        pend[i]      = 1'b1;
                        req_angle[i] = angle_of(int'($urandom_range(0, 90)));
                    end
                end
            end
            req_valid = pend;
            #1;
            model_grant(g, gid);
            n_checks++;
            if (req_ready !== g) begin
                n_errors++;
                $display("FAIL soak_grant[%0d]: got %b expected %b", c, req_ready, g);
            end
            advance(gid);
            if (gid >= 0) pend[gid] = 1'b0;
            if (rsp_valid != '0) seen++;
            n_checks++;
            if (rsp_valid !== e_rsp_valid || rsp_id !== m_rsp_id || rsp_sin !== m_rsp_sin || rsp_cos !== m_rsp_cos) begin
                n_errors++;
                $display("FAIL soak_rsp[%0d]: got valid=%b id=%0d sin=%h cos=%h expected valid=%b id=%0d sin=%h cos=%h",
                         c, rsp_valid, rsp_id, rsp_sin, rsp_cos, e_rsp_valid, m_rsp_id, m_rsp_sin, m_rsp_cos);
            end
            n_checks++;
            if (cs_angle !== m_cs_angle || inflight !== CW'(m_inflight) || int'(inflight) > LAT + 1) begin
                n_errors++;
                $display("FAIL soak_state[%0d]: got cs_angle=%h inflight=%0d expected cs_angle=%h inflight=%0d",
                         c, cs_angle, inflight, m_cs_angle, m_inflight);
            end
        end
        expected_rsp = expected_rsp + (m_acc_total - base_acc);
        n_checks++;
        if (seen != expected_rsp) begin
            n_errors++;
            $display("FAIL soak_rsp_count: got %0d responses expected %0d", seen, expected_rsp);
        end
        n_checks++;
        if (idle !== 1'b1 || inflight !== '0) begin
            n_errors++;
            $display("FAIL soak_final_idle: got idle=%b inflight=%0d expected 1/0", idle, inflight);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_acc_total = 0;
        model_reset();
        @(negedge clock);
        test_reset();
        test_full_contention();
        test_single();
        test_sparse();
        test_midflight_reset();
        test_soak();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
